// File: rtl/router_fsm.sv
// router_fsm
//   Control FSM for the router input stage. It decodes the destination
//   address from the header byte and, when needed, waits for the target
//   output FIFO to drain. It then steps the packet register block through
//   the header, payload, FIFO-full stall and parity check phases using
//   one-hot phase strobes. It also produces the FIFO write enable, the
//   one-hot FIFO select and the source-side busy signal.
//
// Ports
//   clock             system clock, rising edge
//   reset             synchronous, active-high reset
//   pkt_valid         source packet valid
//   data_in[1:0]      low bits of current byte (destination in DECODE_ADDRESS)
//   fifo_full         selected output FIFO full
//   fifo_empty[2:0]   per-port output FIFO empty flags
//   soft_reset[2:0]   per-port read-timeout soft resets
//   parity_done       parity byte captured by the register block
//   low_packet_valid  pkt_valid dropped during load (register block)
//   detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg
//                     one-hot phase strobes
//   write_enb_reg     FIFO write enable
//   write_sel[2:0]    one-hot FIFO select
//   busy              source must hold its current byte
//   drop_count        saturating count of packets dropped for address 3
module router_fsm #(
  parameter int unsigned DROP_CNT_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pkt_valid,
  input  logic [1:0]            data_in,
  input  logic                  fifo_full,
  input  logic [2:0]            fifo_empty,
  input  logic [2:0]            soft_reset,
  input  logic                  parity_done,
  input  logic                  low_packet_valid,
  output logic                  detect_add,
  output logic                  lfd_state,
  output logic                  ld_state,
  output logic                  full_state,
  output logic                  laf_state,
  output logic                  rst_int_reg,
  output logic                  write_enb_reg,
  output logic [2:0]            write_sel,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam logic [3:0] DECODE_ADDRESS     = 4'd0;
  localparam logic [3:0] WAIT_TILL_EMPTY    = 4'd1;
  localparam logic [3:0] LOAD_FIRST_DATA    = 4'd2;
  localparam logic [3:0] LOAD_DATA          = 4'd3;
  localparam logic [3:0] LOAD_PARITY        = 4'd4;
  localparam logic [3:0] FIFO_FULL_STATE    = 4'd5;
  localparam logic [3:0] LOAD_AFTER_FULL    = 4'd6;
  localparam logic [3:0] CHECK_PARITY_ERROR = 4'd7;
  localparam logic [3:0] DROP_PACKET        = 4'd8;

  logic [3:0] state;
  logic [3:0] next_state;
  logic [1:0] addr_reg;
  logic       hdr_accept;
  logic       hdr_drop;

  // Header handling in DECODE_ADDRESS: address 3 has no output port.
  assign hdr_accept = (state == DECODE_ADDRESS) && pkt_valid && (data_in != 2'd3);
  assign hdr_drop   = (state == DECODE_ADDRESS) && pkt_valid && (data_in == 2'd3);

  always_comb begin
    next_state = state;
    unique case (state)
      DECODE_ADDRESS: begin
        if (hdr_drop)
          next_state = DROP_PACKET;
        else if (hdr_accept)
          next_state = fifo_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      end
      DROP_PACKET:        if (!pkt_valid) next_state = DECODE_ADDRESS;
      WAIT_TILL_EMPTY:    if (fifo_empty[addr_reg]) next_state = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:    next_state = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)
          next_state = FIFO_FULL_STATE;
        else if (!pkt_valid)
          next_state = LOAD_PARITY;
      end
      FIFO_FULL_STATE:    if (!fifo_full) next_state = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (parity_done)
          next_state = DECODE_ADDRESS;
        else if (low_packet_valid)
          next_state = LOAD_PARITY;
        else
          next_state = LOAD_DATA;
      end
      LOAD_PARITY:        next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:            next_state = DECODE_ADDRESS;
    endcase
    // A read timeout on the port this packet targets abandons the packet.
    // DA and DROP have no port bound, so they ignore soft resets.
    if ((state != DECODE_ADDRESS) && (state != DROP_PACKET) && soft_reset[addr_reg])
      next_state = DECODE_ADDRESS;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= DECODE_ADDRESS;
      addr_reg   <= '0;
      drop_count <= '0;
    end else begin
      state <= next_state;
      if (hdr_accept)
        addr_reg <= data_in;
      if (hdr_drop && (drop_count != '1))
        drop_count <= drop_count + DROP_CNT_W'(1);
    end
  end

  // Moore output decode: from state and addr_reg only.
  always_comb begin
    detect_add    = (state == DECODE_ADDRESS);
    lfd_state     = (state == LOAD_FIRST_DATA);
    ld_state      = (state == LOAD_DATA);
    full_state    = (state == FIFO_FULL_STATE);
    laf_state     = (state == LOAD_AFTER_FULL);
    rst_int_reg   = (state == CHECK_PARITY_ERROR);
    write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                    (state == LOAD_AFTER_FULL);
    busy          = (state == WAIT_TILL_EMPTY) || (state == LOAD_FIRST_DATA) ||
                    (state == LOAD_PARITY) || (state == FIFO_FULL_STATE) ||
                    (state == LOAD_AFTER_FULL) || (state == CHECK_PARITY_ERROR);
    write_sel = '0;
    if ((state != DECODE_ADDRESS) && (state != WAIT_TILL_EMPTY) &&
        (state != DROP_PACKET)) begin
      unique case (addr_reg)
        2'd0:    write_sel = 3'b001;
        2'd1:    write_sel = 3'b010;
        2'd2:    write_sel = 3'b100;
        default: write_sel = 3'b000;
      endcase
    end
  end

endmodule
